// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone B3 cycle-type, burst-type and responder FSM encodings.
package wb_pkg;
    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_e;
    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;
    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        BURST
    } wb_fsm_e;
endpackage

// File: rtl/wb_burst_addr.sv
// wb_burst_addr: next word address of a Wishbone registered-feedback burst.
module wb_burst_addr
    import wb_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic [AW-1:0] addr_i,
    input  cti_e          cti_i,
    input  bte_e          bte_i,
    output logic [AW-1:0] next_o
);
    logic [AW-1:0] mask;
    logic [AW-1:0] inc;
    // Only the masked low bits advance, so wrap bursts stay inside their aligned block.
    assign inc  = addr_i + AW'(1);
    assign mask = bte_i == BTE_WRAP4  ? AW'(3)  :
                  bte_i == BTE_WRAP8  ? AW'(7)  :
                  bte_i == BTE_WRAP16 ? AW'(15) : '1;
    assign next_o = cti_i == CTI_INCR ? (addr_i & ~mask) | (inc & mask) : addr_i;
endmodule

// File: rtl/wb_ram_responder.sv
// wb_ram_responder: Wishbone B3 slave over a byte-enabled RAM, classic and burst cycles.
// Define WB_RAM_RESPONDER_ERR_EN to answer out-of-range word indices with err_o.
module wb_ram_responder
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o,
    output logic                    err_o,
    output logic                    rty_o,
    output logic [DATA_WIDTH-1:0]   dat_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int WB = $clog2(NB);
    localparam int MW = $clog2(MEM_WORDS);

    wb_fsm_e               state_q, state_d;
    logic                  ack_q, ack_d, err_q, err_d;
    logic [MW-1:0]         addr_q, addr_d, next_addr, adr_word, rd_addr;
    logic [DATA_WIDTH-1:0] dat_q, dat_d, rd_data;
    logic [NB-1:0][7:0]    mem_q [MEM_WORDS];
    logic                  oor, req, wr_en, load, cont;
    logic                  unused_adr;

`ifdef WB_RAM_RESPONDER_ERR_EN
    assign oor        = |adr_i[ADDR_WIDTH-1:WB+MW];
    assign unused_adr = ^adr_i[WB-1:0];
`else
    assign oor        = 1'b0;
    assign unused_adr = ^{adr_i[ADDR_WIDTH-1:WB+MW], adr_i[WB-1:0]};
`endif

    assign adr_word = adr_i[WB +: MW];
    assign req      = cyc_i & stb_i;
    assign ack_o    = ack_q & req;
    assign err_o    = err_q & req;
    assign rty_o    = 1'b0;
    assign dat_o    = dat_q;
    assign wr_en    = ack_o & we_i;
    assign cont     = cti_i == CTI_CONST || cti_i == CTI_INCR;

    wb_burst_addr #(.AW(MW)) u_next (
        .addr_i (addr_q),
        .cti_i  (cti_e'(cti_i)),
        .bte_i  (bte_e'(bte_i)),
        .next_o (next_addr)
    );

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        addr_d  = addr_q;
        rd_addr = addr_q;
        load    = 1'b0;
        if (!cyc_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (stb_i) begin
                    state_d = cont ? BURST : SINGLE;
                    addr_d  = adr_word;
                    rd_addr = adr_word;
                    load    = 1'b1;
                    ack_d   = ~oor;
                    err_d   = oor;
                end
                SINGLE: state_d = IDLE;
                BURST: if (stb_i && (ack_q || err_q)) begin
                    state_d = cont ? BURST : IDLE;
                    addr_d  = cont ? next_addr : addr_q;
                    rd_addr = next_addr;
                    load    = cont;
                    ack_d   = cont & ack_q;
                    err_d   = cont & err_q;
                end else if (stb_i) begin
                    // Re-entry after a wait state: re-capture like IDLE, keep bursting.
                    addr_d  = adr_word;
                    rd_addr = adr_word;
                    load    = 1'b1;
                    ack_d   = ~oor;
                    err_d   = oor;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Write-first: a beat written this cycle is visible to the read issued alongside it.
    always_comb begin
        rd_data = mem_q[rd_addr];
        for (int b = 0; b < NB; b++)
            if (wr_en && adr_word == rd_addr && sel_i[b]) rd_data[8*b +: 8] = dat_i[8*b +: 8];
    end

    assign dat_d = load ? (err_d ? '0 : rd_data) : dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            for (int b = 0; b < NB; b++)
                if (sel_i[b]) mem_q[adr_word][b] <= dat_i[8*b +: 8];
    end
endmodule

// File: tb/tb_wb_ram_responder.sv
// tb_wb_ram_responder: directed Wishbone master with a word-array memory model and per-cycle checker.
module tb_wb_ram_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc_i, stb_i, we_i;
    logic [31:0] adr_i, dat_i;
    logic [3:0]  sel_i;
    logic [2:0]  cti_i;
    logic [1:0]  bte_i;
    logic        ack_o, err_o, rty_o;
    logic [31:0] dat_o;

    always #5 clk = ~clk;

    wb_ram_responder dut (
        .clk(clk), .rst(rst), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
        .dat_i(dat_i), .sel_i(sel_i), .cti_i(cti_i), .bte_i(bte_i),
        .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o), .dat_o(dat_o)
    );

`ifdef WB_RAM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic [31:0] model [1024];
    logic [31:0] got [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        chk_on = 1'b0;
    logic        exp_ack = 1'b0, exp_err = 1'b0, chk_dat = 1'b0;
    logic [31:0] exp_dat = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("ack_o", 32'(ack_o), 32'(exp_ack));
            check("err_o", 32'(err_o), 32'(exp_err));
            check("rty_o", 32'(rty_o), 32'd0);
            if (exp_ack && chk_dat) check("dat_o", dat_o, exp_dat);
            if (ack_o) got.push_back(dat_o);
        end
    end

    function automatic logic oor(input logic [31:0] a);
        return ERR_EN && a[31:12] != 20'd0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
        return o;
    endfunction

    // Address of beat i: constant bursts stay put, incrementing ones wrap inside an aligned block.
    function automatic logic [9:0] baddr(input int s, input int i, input logic [2:0] ct, input logic [1:0] bt);
        int l = bt == 2'd0 ? 1024 : 2 << bt;
        if (ct == 3'b001) return 10'(s);
        return 10'((s & ~(l - 1)) | ((s + i) & (l - 1)));
    endfunction

    task automatic bus(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] sl, input logic [2:0] ct, input logic [1:0] bt);
        cyc_i = c; stb_i = s; we_i = w; adr_i = a; dat_i = d; sel_i = sl; cti_i = ct; bte_i = bt;
    endtask

    task automatic step(input logic ea, input logic ee, input logic cd, input logic [31:0] ed);
        exp_ack = ea; exp_err = ee; chk_dat = cd; exp_dat = ed;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus(0, 0, 0, '0, '0, '0, 3'b000, 2'b00);
        step(0, 0, 0, '0);
    endtask

    task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
        logic       o = oor(a);
        logic [9:0] wi = a[11:2];
        bus(1, 1, w, a, d, sl, 3'b000, 2'b00);
        step(0, 0, 0, '0);
        step(!o, o, !w, model[wi]);
        if (w && !o) model[wi] = merge(model[wi], d, sl);
        idle();
    endtask

    task automatic burst(input logic w, input int s, input int n, input logic [2:0] ct, input logic [1:0] bt,
                         input int gap_beat, input int gap_len, input logic [31:0] base);
        logic [9:0] a;
        bus(1, 1, w, {20'd0, baddr(s, 0, ct, bt), 2'b00}, base, 4'hF, n == 1 ? 3'b111 : ct, bt);
        step(0, 0, 0, '0);
        for (int i = 0; i < n; i++) begin
            a = baddr(s, i, ct, bt);
            bus(1, 1, w, {20'd0, a, 2'b00}, base + 32'(i), 4'hF, i == n - 1 ? 3'b111 : ct, bt);
            step(1, 0, !w, model[a]);
            if (w) model[a] = base + 32'(i);
            if (i == gap_beat && i != n - 1) begin
                for (int g = 0; g < gap_len; g++) begin
                    stb_i = 1'b0;
                    step(0, 0, 0, '0);
                end
                bus(1, 1, w, {20'd0, baddr(s, i + 1, ct, bt), 2'b00}, base, 4'hF, ct, bt);
                step(0, 0, 0, '0);
            end
        end
        idle();
    endtask

    initial begin
        logic [31:0] t3 [4] = '{32'd6, 32'd7, 32'd4, 32'd5};
        bus(0, 0, 0, '0, '0, '0, 3'b000, 2'b00);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        chk_on = 1'b1;
        step(0, 0, 0, '0);
        check("dat_o reset", dat_o, 32'd0);
        rst = 1'b0;
        idle();

        // classic write then read, byte-lane write
        classic(1, 32'h10, 32'hDEADBEEF, 4'hF);
        got.delete();
        classic(0, 32'h10, '0, 4'hF);
        check("t1 size", 32'(got.size()), 32'd1);
        check("t1 data", got[0], 32'hDEADBEEF);
        classic(1, 32'h10, 32'h0000AB00, 4'b0010);
        check("t2 model", model[4], 32'hDEADABEF);
        got.delete();
        classic(0, 32'h10, '0, 4'hF);
        check("t2 data", got[0], 32'hDEADABEF);

        // wrap-4 incrementing read burst starting mid-block
        for (int w = 4; w < 8; w++) classic(1, 32'(w * 4), 32'(w), 4'hF);
        got.delete();
        burst(0, 6, 4, 3'b010, 2'b01, -1, 0, '0);
        check("t3 size", 32'(got.size()), 32'd4);
        for (int k = 0; k < 4; k++) check("t3 data", got[k], t3[k]);

        // linear write burst with a two-cycle wait after beat 3, then readback
        burst(1, 0, 8, 3'b010, 2'b00, 2, 2, 32'hA000_0000);
        got.delete();
        burst(0, 0, 8, 3'b010, 2'b00, -1, 0, '0);
        check("t4 size", 32'(got.size()), 32'd8);
        check("t4 last", got[7], 32'hA000_0007);
        got.delete();
        burst(0, 3, 3, 3'b001, 2'b00, -1, 0, '0);
        check("const burst", got[2], 32'hA000_0003);

        // cyc dropped mid-burst, reset pulse, then classic read
        bus(1, 1, 0, 32'h0, '0, 4'hF, 3'b010, 2'b00);
        step(0, 0, 0, '0);
        step(1, 0, 1, model[0]);
        adr_i = 32'h4;
        step(1, 0, 1, model[1]);
        idle();
        rst = 1'b1;
        step(0, 0, 0, '0);
        rst = 1'b0;
        classic(0, 32'h8, '0, 4'hF);

        // reset asserted while a burst beat is being acknowledged
        bus(1, 1, 0, 32'h0, '0, 4'hF, 3'b010, 2'b00);
        step(0, 0, 0, '0);
        step(1, 0, 1, model[0]);
        adr_i = 32'h4;
        chk_on = 1'b0;
        rst = 1'b1;
        step(0, 0, 0, '0);
        rst = 1'b0;
        chk_on = 1'b1;
        bus(1, 1, 0, 32'h0, '0, 4'hF, 3'b000, 2'b00);
        step(0, 0, 0, '0);
        step(1, 0, 1, model[0]);
        idle();

        // out-of-range address: error response or alias onto word 0
        classic(1, 32'h1000, 32'h5A5A5A5A, 4'hF);
        got.delete();
        classic(0, 32'h0, '0, 4'hF);
        check("t6 word0", got[0], ERR_EN ? 32'hA000_0000 : 32'h5A5A5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
